// File: rtl/pipelined_acc_adder_tree.sv
// Pipelined 4:2/3:2 carry-save reduction of N_IN signed operands with multi-beat accumulation.
// Optional macro ACC_SAT_EN: saturating accumulator plus sticky out_ovf flag.
module pipelined_acc_adder_tree #(
    parameter int N_IN  = 10,
    parameter int IN_W  = 63,
    parameter int ACC_W = 66,
    parameter int PIPE  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN*IN_W-1:0] in_data,
    input  logic                 acc_start,
    input  logic                 acc_last,
    input  logic [2:0]           mode,
    input  logic                 sign64,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic [ACC_W-1:0]     out_mag,
`ifdef ACC_SAT_EN
    output logic                 out_ovf,
`endif
    output logic                 out_sign
);

    function automatic int rows_next(input int n);
        return (n / 4) * 2 + ((n % 4 == 3) ? 2 : (n % 4));
    endfunction

    function automatic int rows_at(input int lvl);
        int n;
        n = N_IN;
        for (int i = 0; i < lvl; i++) n = rows_next(n);
        return n;
    endfunction

    function automatic int count_levels();
        int n;
        int c;
        n = N_IN;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            if (n > 2) begin
                n = rows_next(n);
                c++;
            end
        end
        return c;
    endfunction

    localparam int NLEV = count_levels();

    // Register boundaries are distributed so that PIPE stages land evenly across NLEV levels.
    function automatic int stages_upto(input int lvl);
        return (lvl * PIPE) / NLEV;
    endfunction

    function automatic logic [2*ACC_W-1:0] csa32(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b,
                                                 input logic [ACC_W-1:0] c);
        logic [ACC_W-1:0] s;
        logic [ACC_W-1:0] cy;
        s  = a ^ b ^ c;
        cy = ((a & b) | (a & c) | (b & c)) << 1;
        return {cy, s};
    endfunction

    function automatic logic signed [ACC_W-1:0] magnitude(input logic signed [ACC_W-1:0] v);
        return v[ACC_W-1] ? -v : v;
    endfunction

    function automatic logic sign_sel(input logic [2:0] m, input logic s,
                                      input logic signed [ACC_W-1:0] v);
        case (m)
            3'b000, 3'b001, 3'b011, 3'b100: return v[ACC_W-1];
            default:                        return s;
        endcase
    endfunction

`ifdef ACC_SAT_EN
    function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                     input logic signed [ACC_W-1:0] b,
                                     input logic signed [ACC_W-1:0] s);
        return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_val(input logic neg);
        return neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    endfunction
`endif

    logic       adv;
    logic       vld_in;
    logic [5:0] tag_in;
    logic       vld_fs;
    logic [5:0] tag_fs;

    assign adv      = ~(out_valid & ~out_ready);
    assign in_ready = ~rst & adv;
    assign vld_in   = in_valid & in_ready;
    assign tag_in   = {acc_start, acc_last, mode, sign64};

    // Input: sign-extend every operand to the accumulator width.
    logic [N_IN*ACC_W-1:0] ext_rows;
    for (genvar k = 0; k < N_IN; k++) begin : g_ext
        logic signed [IN_W-1:0] op;
        assign op = in_data[k*IN_W +: IN_W];
        assign ext_rows[k*ACC_W +: ACC_W] = {{(ACC_W-IN_W){op[IN_W-1]}}, op};
    end

    // Tree levels: each level compresses groups of 4 rows, then a trailing 3, and passes 1-2 through.
    for (genvar l = 0; l < NLEV; l++) begin : g_lvl
        localparam int NI   = rows_at(l);
        localparam int NO   = rows_at(l + 1);
        localparam int NQ   = NI / 4;
        localparam int REM  = NI % 4;
        localparam int NREG = stages_upto(l + 1) - stages_upto(l);
        logic [NI*ACC_W-1:0] d;
        logic [NO*ACC_W-1:0] c;
        logic [NO*ACC_W-1:0] q;

        if (l == 0) begin : g_src
            assign d = ext_rows;
        end else begin : g_src
            assign d = g_lvl[l-1].q;
        end

        for (genvar g = 0; g < NQ; g++) begin : g_c42
            logic [2*ACC_W-1:0] t0;
            logic [2*ACC_W-1:0] t1;
            assign t0 = csa32(d[(4*g)*ACC_W +: ACC_W], d[(4*g+1)*ACC_W +: ACC_W],
                              d[(4*g+2)*ACC_W +: ACC_W]);
            assign t1 = csa32(t0[0 +: ACC_W], t0[ACC_W +: ACC_W], d[(4*g+3)*ACC_W +: ACC_W]);
            assign c[(2*g)*ACC_W +: 2*ACC_W] = t1;
        end

        if (REM == 3) begin : g_rem
            assign c[(2*NQ)*ACC_W +: 2*ACC_W] = csa32(d[(4*NQ)*ACC_W +: ACC_W],
                                                      d[(4*NQ+1)*ACC_W +: ACC_W],
                                                      d[(4*NQ+2)*ACC_W +: ACC_W]);
        end else if (REM != 0) begin : g_rem
            assign c[(2*NQ)*ACC_W +: REM*ACC_W] = d[(4*NQ)*ACC_W +: REM*ACC_W];
        end

        if (NREG == 0) begin : g_reg
            assign q = c;
        end else begin : g_reg
            logic [NO*ACC_W-1:0] r [NREG];
            always_ff @(posedge clk) begin
                if (adv) begin
                    r[0] <= c;
                    for (int i = 1; i < NREG; i++) r[i] <= r[i-1];
                end
            end
            assign q = r[NREG-1];
        end
    end

    // Control side: valid and beat tags follow the tree through the same PIPE stages.
    if (PIPE == 0) begin : g_side
        assign vld_fs = vld_in;
        assign tag_fs = tag_in;
    end else begin : g_side
        logic [PIPE-1:0] vld_p;
        logic [5:0]      tag_p [PIPE];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_p <= '0;
            end else if (adv) begin
                vld_p[0] <= vld_in;
                for (int i = 1; i < PIPE; i++) vld_p[i] <= vld_p[i-1];
            end
        end
        always_ff @(posedge clk) begin
            if (adv) begin
                tag_p[0] <= tag_in;
                for (int i = 1; i < PIPE; i++) tag_p[i] <= tag_p[i-1];
            end
        end
        assign vld_fs = vld_p[PIPE-1];
        assign tag_fs = tag_p[PIPE-1];
    end

    // Final stage: carry-propagate add of the two remaining rows and accumulate.
    logic                    start_fs;
    logic                    last_fs;
    logic [2:0]              mode_fs;
    logic                    sign_fs;
    logic signed [ACC_W-1:0] tree_sum;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_next;

    assign {start_fs, last_fs, mode_fs, sign_fs} = tag_fs;
    assign tree_sum = g_lvl[NLEV-1].q[0 +: ACC_W] + g_lvl[NLEV-1].q[ACC_W +: ACC_W];
    assign acc_base = start_fs ? '0 : acc;

`ifdef ACC_SAT_EN
    logic signed [ACC_W-1:0] acc_wrap;
    logic                    acc_ovf;
    logic                    ovf_q;
    logic                    ovf_next;
    assign acc_wrap = acc_base + tree_sum;
    assign acc_ovf  = add_ovf(acc_base, tree_sum, acc_wrap);
    assign acc_next = acc_ovf ? sat_val(acc_base[ACC_W-1]) : acc_wrap;
    assign ovf_next = (start_fs ? 1'b0 : ovf_q) | acc_ovf;
`else
    assign acc_next = acc_base + tree_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_mag   <= '0;
            out_sign  <= 1'b0;
`ifdef ACC_SAT_EN
            ovf_q     <= 1'b0;
            out_ovf   <= 1'b0;
`endif
        end else if (adv) begin
            out_valid <= vld_fs & last_fs;
            if (vld_fs) begin
                acc <= acc_next;
`ifdef ACC_SAT_EN
                ovf_q <= ovf_next;
`endif
                if (last_fs) begin
                    out_sum  <= acc_next;
                    out_mag  <= magnitude(acc_next);
                    out_sign <= sign_sel(mode_fs, sign_fs, acc_next);
`ifdef ACC_SAT_EN
                    out_ovf  <= ovf_next;
`endif
                end
            end
        end
    end

endmodule
